serial_pattern_gen: RTL and testbench

Serial bit-stream generator that drives the single-bit input of the sequence-detector FSMs (e.g. the 11001 Moore detectors). It accepts a parallel pattern through a valid/ready load port and shifts it out MSB first, one bit per clock, repeated a programmable number of times. It supports stall, abort, and an end-of-frame pulse. It sits between a stimulus/control source and any serial detector, and is the transmit-side counterpart of the detector.

---
 rtl/serial_gen_pkg.sv | 32 +++
 rtl/serial_gen_counter.sv | 56 +++++
 rtl/serial_pattern_gen.sv | 191 +++++++++++++++++++
 tb/tb_serial_pattern_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_gen_pkg.sv
// -----------------------------------------------------------------------------
// serial_gen_pkg
// Shared definitions for the serial pattern generator:
//   state_t     - FSM state encoding (IDLE, SHIFT, DONE)
//   DEF_MAX_LEN - default pattern register width
//   DEF_REP_W   - default pass-count field width
//   clamp_len   - limits a requested length to the pattern register width
// -----------------------------------------------------------------------------
package serial_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 32;
  localparam int DEF_REP_W   = 8;

  // Requests longer than the pattern register are trimmed to its width.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    int unsigned res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_gen_counter.sv
// -----------------------------------------------------------------------------
// serial_gen_counter
// Loadable down-counter. A load has priority over a decrement, and the count
// saturates at zero instead of wrapping.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset (clears the count)
//   load     - load load_val on the next edge
//   load_val - value to load
//   en       - decrement on the next edge (ignored at zero)
//   count    - current count
//   tc       - terminal count, high while count == 0
// -----------------------------------------------------------------------------
module serial_gen_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next-count selection: load, saturating decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/serial_pattern_gen.sv
// -----------------------------------------------------------------------------
// serial_pattern_gen
// Shifts a parallel pattern out MSB first, one bit per clock, for a
// programmable number of passes. Supports hold (stall), abort and an
// end-of-frame pulse.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   load_valid/load_ready - load handshake (ready only in IDLE)
//   load_pattern          - pattern, bit load_len-1 sent first
//   load_len              - bits per pass (clamped to MAX_LEN)
//   load_repeat           - number of passes (0 behaves as 1)
//   hold                  - freeze bit index and pass count
//   abort                 - end the frame at the next edge, no frame_done
//   ser_out, ser_valid    - registered serial bit and its qualifier
//   frame_done            - registered one-cycle end-of-frame pulse
//   busy                  - high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module serial_pattern_gen
  import serial_gen_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int REP_W   = DEF_REP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_pattern,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [REP_W-1:0]   load_repeat,
  input  logic               hold,
  input  logic               abort,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] PASS_ZERO = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] PASS_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

  state_t               state_d,      state_q;
  logic [MAX_LEN-1:0]   pat_d,        pat_q;
  logic [LEN_W-1:0]     len_d,        len_q;
  logic                 ser_out_d,    ser_out_q;
  logic                 ser_valid_d,  ser_valid_q;
  logic                 frame_done_d, frame_done_q;

  logic                 idx_load_s;
  logic [LEN_W-1:0]     idx_load_val_s;
  logic                 idx_en_s;
  logic [LEN_W-1:0]     idx_cnt_s;
  logic                 idx_tc_s;

  logic                 pass_load_s;
  logic [REP_W-1:0]     pass_load_val_s;
  logic                 pass_en_s;
  logic [REP_W-1:0]     pass_cnt_s;
  logic                 pass_tc_s;

  logic [LEN_W-1:0]     ld_len_s;
  logic [REP_W-1:0]     ld_pass_s;
  logic [MAX_LEN-1:0]   ld_shift_s;
  logic [LEN_W-1:0]     nxt_idx_s;
  logic [MAX_LEN-1:0]   run_shift_s;

  // Load-side decode: clamped length, remaining passes after the first one,
  // and the first bit to send.
  assign ld_len_s   = LEN_W'(clamp_len(32'(load_len), MAX_LEN));
  assign ld_pass_s  = (load_repeat == PASS_ZERO) ? PASS_ZERO : (load_repeat - PASS_ONE);
  assign ld_shift_s = load_pattern >> (ld_len_s - LEN_ONE);

  // The bit index counts the bit currently on ser_out; the next bit either
  // comes from a decrement or from the reload at a pass boundary.
  assign nxt_idx_s   = idx_tc_s ? (len_q - LEN_ONE) : (idx_cnt_s - LEN_ONE);
  assign run_shift_s = pat_q >> nxt_idx_s;

  serial_gen_counter #(.W(LEN_W)) u_idx_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (idx_load_s),
    .load_val (idx_load_val_s),
    .en       (idx_en_s),
    .count    (idx_cnt_s),
    .tc       (idx_tc_s)
  );

  serial_gen_counter #(.W(REP_W)) u_pass_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (pass_load_s),
    .load_val (pass_load_val_s),
    .en       (pass_en_s),
    .count    (pass_cnt_s),
    .tc       (pass_tc_s)
  );

  // FSM next state, counter controls and next values of the output registers.
  always_comb begin
    state_d         = state_q;
    pat_d           = pat_q;
    len_d           = len_q;
    ser_out_d       = 1'b0;
    ser_valid_d     = 1'b0;
    frame_done_d    = 1'b0;
    idx_load_s      = 1'b0;
    idx_load_val_s  = nxt_idx_s;
    idx_en_s        = 1'b0;
    pass_load_s     = 1'b0;
    pass_load_val_s = ld_pass_s;
    pass_en_s       = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          pat_d       = load_pattern;
          len_d       = ld_len_s;
          pass_load_s = 1'b1;
          if (ld_len_s == LEN_ZERO) begin
            // Empty frame: nothing to shift, still signal completion.
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d        = SHIFT;
            idx_load_s     = 1'b1;
            idx_load_val_s = ld_len_s - LEN_ONE;
            ser_out_d      = ld_shift_s[0];
            ser_valid_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hold) begin
          // Keep the last bit on the line but mark it as not live.
          ser_out_d = ser_out_q;
        end else if (idx_tc_s && pass_tc_s) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end else begin
          idx_load_s  = idx_tc_s;
          idx_en_s    = !idx_tc_s;
          pass_en_s   = idx_tc_s && (pass_cnt_s != PASS_ZERO);
          ser_out_d   = run_shift_s[0];
          ser_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pattern and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pat_q        <= {MAX_LEN{1'b0}};
      len_q        <= LEN_ZERO;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_done = frame_done_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_gen
// Directed self-checking bench for serial_pattern_gen with hand-computed
// expected bit streams and handshake timing.
// -----------------------------------------------------------------------------
module tb_serial_pattern_gen;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int REP_W   = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_pattern;
  logic [LEN_W-1:0]   load_len;
  logic [REP_W-1:0]   load_repeat;
  logic               hold;
  logic               abort;
  logic               ser_out;
  logic               ser_valid;
  logic               frame_done;
  logic               busy;

  int tests = 0;
  int fails = 0;

  logic [63:0] bits;
  int          nv;

  serial_pattern_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
    .hold         (hold),
    .abort        (abort),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] p, input logic [5:0] l, input logic [7:0] r);
    load_pattern = p;
    load_len     = l;
    load_repeat  = r;
    load_valid   = 1'b1;
    tick();
    load_valid   = 1'b0;
  endtask

  task automatic collect(input int n, output logic [63:0] b, output int nvalid);
    b = 64'd0;
    nvalid = 0;
    for (int i = 0; i < n; i++) begin
      if (ser_valid) nvalid++;
      b = {b[62:0], ser_out};
      tick();
    end
  endtask

  // Non-overlapping 11001 detector applied to the n-bit stream (oldest bit is MSB).
  function automatic int count_11001(input logic [63:0] b, input int n);
    logic [4:0] sh;
    int fill;
    int c;
    sh = 5'b0;
    fill = 0;
    c = 0;
    for (int i = n - 1; i >= 0; i--) begin
      sh = {sh[3:0], b[i]};
      fill++;
      if (fill >= 5 && sh == 5'b11001) begin
        c++;
        fill = 0;
      end
    end
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    load_valid   = 1'b0;
    load_pattern = 32'd0;
    load_len     = 6'd0;
    load_repeat  = 8'd0;
    hold         = 1'b0;
    abort        = 1'b0;

    // Reset state
    #12;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b1;
    tick();

    // 11001 x 3 passes
    load(32'b11001, 6'd5, 8'd3);
    collect(15, bits, nv);
    chk("t1_bits", bits, 64'b110011100111001);
    chk("t1_valid_cycles", nv, 15);
    chk("t1_detects", count_11001(bits, 15), 3);
    chk("t1_frame_done", frame_done, 1);
    chk("t1_valid_at_done", ser_valid, 0);
    chk("t1_ready_at_done", load_ready, 0);
    tick();
    chk("t1_ready_after", load_ready, 1);
    chk("t1_done_single", frame_done, 0);
    chk("t1_busy_after", busy, 0);

    // 24-bit pattern, one pass
    load(32'b110011100110011001101100, 6'd24, 8'd1);
    collect(24, bits, nv);
    chk("t2_bits", bits, 64'b110011100110011001101100);
    chk("t2_valid_cycles", nv, 24);
    chk("t2_frame_done", frame_done, 1);
    tick();

    // Hold for 3 cycles after the 2nd bit
    load(32'b11001, 6'd5, 8'd3);
    collect(1, bits, nv);
    chk("t3_bit2_out", ser_out, 1);
    chk("t3_bit2_valid", ser_valid, 1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_hold_valid", ser_valid, 0);
      chk("t3_hold_out", ser_out, 1);
    end
    hold = 1'b0;
    tick();
    collect(13, bits, nv);
    chk("t3_bits_after_hold", bits, 64'b0011100111001);
    chk("t3_valid_cycles", nv, 13);
    chk("t3_frame_done_delayed", frame_done, 1);
    tick();

    // Abort during bit 3 of pass 2, then immediate reload
    load(32'b11001, 6'd5, 8'd3);
    collect(7, bits, nv);
    chk("t4_pre_abort_bits", bits, 64'b1100111);
    chk("t4_bit3_out", ser_out, 0);
    chk("t4_bit3_valid", ser_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_ready", load_ready, 1);
    chk("t4_abort_valid", ser_valid, 0);
    chk("t4_abort_out", ser_out, 0);
    chk("t4_abort_no_done", frame_done, 0);
    load(32'b101, 6'd3, 8'd1);
    collect(3, bits, nv);
    chk("t4_reload_bits", bits, 64'b101);
    chk("t4_reload_valid", nv, 3);
    chk("t4_reload_done", frame_done, 1);
    tick();

    // Length 0: frame_done only
    load(32'hFFFF_FFFF, 6'd0, 8'd5);
    chk("t5_done", frame_done, 1);
    chk("t5_valid", ser_valid, 0);
    chk("t5_busy", busy, 1);
    chk("t5_ready", load_ready, 0);
    tick();
    chk("t5_ready_after", load_ready, 1);
    chk("t5_done_after", frame_done, 0);

    // Length 40 is clamped to 32
    load(32'hA5C3_0F96, 6'd40, 8'd1);
    collect(32, bits, nv);
    chk("t6_bits", bits, 64'h0000_0000_A5C3_0F96);
    chk("t6_valid_cycles", nv, 32);
    chk("t6_done", frame_done, 1);
    chk("t6_valid_at_done", ser_valid, 0);
    tick();

    // Repeat 0 = one pass; abort in IDLE still loads; load_valid held while busy ignored
    load_pattern = 32'b1011;
    load_len     = 6'd4;
    load_repeat  = 8'd0;
    load_valid   = 1'b1;
    abort        = 1'b1;
    tick();
    abort        = 1'b0;
    load_pattern = 32'h0000_0000;
    load_len     = 6'd8;
    load_repeat  = 8'd2;
    collect(4, bits, nv);
    chk("t7_bits", bits, 64'b1011);
    chk("t7_valid_cycles", nv, 4);
    chk("t7_done", frame_done, 1);
    tick();
    chk("t7_idle_busy", busy, 0);
    chk("t7_idle_ready", load_ready, 1);
    chk("t7_idle_valid", ser_valid, 0);
    load_valid = 1'b0;
    tick();
    chk("t7_no_reload", busy, 0);

    // Asynchronous reset mid-SHIFT
    load(32'hFFFF_FFFF, 6'd32, 8'd1);
    tick();
    tick();
    chk("t8_shifting_valid", ser_valid, 1);
    chk("t8_shifting_out", ser_out, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t8_rst_out", ser_out, 0);
    chk("t8_rst_valid", ser_valid, 0);
    chk("t8_rst_done", frame_done, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_ready", load_ready, 1);
    #2;
    reset = 1'b1;
    tick();
    chk("t8_post_busy", busy, 0);
    chk("t8_post_done", frame_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
